// File: rtl/tap_controller.sv
// IEEE 1149.1-style TAP controller: 16-state TAP FSM, instruction and bypass registers, DR-mux select.
// Optional 32-bit IDCODE register is compiled in when JTAG_IDCODE_EN is defined.
module tap_controller #(
  parameter int unsigned          IR_WIDTH     = 4,
  parameter logic [IR_WIDTH-1:0]  OPC_EXTEST   = 4'b0000,
  parameter logic [IR_WIDTH-1:0]  OPC_SAMPLE   = 4'b0010,
  parameter logic [IR_WIDTH-1:0]  OPC_IDCODE   = 4'b0001,
  parameter logic [IR_WIDTH-1:0]  OPC_BYPASS   = 4'b1111,
  parameter logic [31:0]          IDCODE_VALUE = 32'h1000_0001
) (
  input  logic       TCK,
  input  logic       TRSTn,
  input  logic       TMS,
  input  logic       TDI,
  input  logic       DR,
  output logic       sel,
  output logic       BR,
  output logic       ShiftDR,
  output logic       CaptureDR,
  output logic       UpdateDR,
  output logic       Mode,
  output logic       TDO,
  output logic       TDO_en,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_TLR   = 4'hF,
    S_RTI   = 4'hC,
    S_SELDR = 4'h7,
    S_CAPDR = 4'h6,
    S_SHDR  = 4'h2,
    S_EX1DR = 4'h1,
    S_PAUDR = 4'h3,
    S_EX2DR = 4'h0,
    S_UPDDR = 4'h5,
    S_SELIR = 4'h4,
    S_CAPIR = 4'hE,
    S_SHIR  = 4'hA,
    S_EX1IR = 4'h9,
    S_PAUIR = 4'hB,
    S_EX2IR = 4'h8,
    S_UPDIR = 4'hD
  } tap_state_e;

  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);
`ifdef JTAG_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] IR_RESET   = OPC_IDCODE;
`else
  localparam logic [IR_WIDTH-1:0] IR_RESET   = OPC_BYPASS;
`endif

  tap_state_e          state_q;
  tap_state_e          state_d;
  logic [IR_WIDTH-1:0] ir_shift_q;
  logic [IR_WIDTH-1:0] ir_q;
  logic                br_q;
  logic                tdo_q;
  logic                tdo_en_q;
  logic                sel_s;
  logic                mode_s;
  logic                dr_tdo_s;

  function automatic tap_state_e next_state(input tap_state_e cur, input logic tms);
    tap_state_e nxt;
    case (cur)
      S_TLR:   nxt = tms ? S_TLR   : S_RTI;
      S_RTI:   nxt = tms ? S_SELDR : S_RTI;
      S_SELDR: nxt = tms ? S_SELIR : S_CAPDR;
      S_CAPDR: nxt = tms ? S_EX1DR : S_SHDR;
      S_SHDR:  nxt = tms ? S_EX1DR : S_SHDR;
      S_EX1DR: nxt = tms ? S_UPDDR : S_PAUDR;
      S_PAUDR: nxt = tms ? S_EX2DR : S_PAUDR;
      S_EX2DR: nxt = tms ? S_UPDDR : S_SHDR;
      S_UPDDR: nxt = tms ? S_SELDR : S_RTI;
      S_SELIR: nxt = tms ? S_TLR   : S_CAPIR;
      S_CAPIR: nxt = tms ? S_EX1IR : S_SHIR;
      S_SHIR:  nxt = tms ? S_EX1IR : S_SHIR;
      S_EX1IR: nxt = tms ? S_UPDIR : S_PAUIR;
      S_PAUIR: nxt = tms ? S_EX2IR : S_PAUIR;
      S_EX2IR: nxt = tms ? S_UPDIR : S_SHIR;
      S_UPDIR: nxt = tms ? S_SELDR : S_RTI;
      default: nxt = S_TLR;
    endcase
    return nxt;
  endfunction

  // TAP state transition from TMS
  always_comb begin
    state_d = next_state(state_q, TMS);
  end

  // Instruction decode; undefined opcodes (and IDCODE) fall through to the bypass select
  always_comb begin
    sel_s  = 1'b1;
    mode_s = 1'b0;
    if (ir_q == OPC_EXTEST) begin
      sel_s  = 1'b0;
      mode_s = 1'b1;
    end else if (ir_q == OPC_SAMPLE) begin
      sel_s  = 1'b0;
      mode_s = 1'b0;
    end else begin
      sel_s  = 1'b1;
      mode_s = 1'b0;
    end
  end

`ifdef JTAG_IDCODE_EN
  logic [31:0] idcode_q;
  logic        idcode_sel_s;

  assign idcode_sel_s = (ir_q == OPC_IDCODE);
  assign dr_tdo_s     = idcode_sel_s ? idcode_q[0] : DR;

  // ID register: captured in CapDR, shifted right in ShDR with TDI into bit 31
  always_ff @(posedge TCK or negedge TRSTn) begin
    if (!TRSTn) begin
      idcode_q <= IDCODE_VALUE;
    end else begin
      case (state_q)
        S_CAPDR: idcode_q <= IDCODE_VALUE;
        S_SHDR:  idcode_q <= {TDI, idcode_q[31:1]};
        default: idcode_q <= idcode_q;
      endcase
    end
  end
`else
  logic unused_idcode_s;

  assign unused_idcode_s = ^{IDCODE_VALUE, OPC_IDCODE};
  assign dr_tdo_s        = DR;
`endif

  // Rising-edge state: TAP state, IR shift stage and bypass bit
  always_ff @(posedge TCK or negedge TRSTn) begin
    if (!TRSTn) begin
      state_q    <= S_TLR;
      ir_shift_q <= '0;
      br_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_TLR: begin
          ir_shift_q <= '0;
          br_q       <= 1'b0;
        end
        S_CAPIR: ir_shift_q <= IR_CAPTURE;
        S_SHIR:  ir_shift_q <= {TDI, ir_shift_q[IR_WIDTH-1:1]};
        S_CAPDR: br_q       <= sel_s ? 1'b0 : br_q;
        S_SHDR:  br_q       <= sel_s ? TDI : br_q;
        default: br_q       <= br_q;
      endcase
    end
  end

  // Falling-edge state: IR update and TDO launch, so TDO is stable around the next rising edge
  always_ff @(negedge TCK or negedge TRSTn) begin
    if (!TRSTn) begin
      ir_q     <= IR_RESET;
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      case (state_q)
        S_TLR: begin
          ir_q     <= IR_RESET;
          tdo_q    <= 1'b0;
          tdo_en_q <= 1'b0;
        end
        S_UPDIR: begin
          ir_q     <= ir_shift_q;
          tdo_q    <= 1'b0;
          tdo_en_q <= 1'b0;
        end
        S_SHIR: begin
          tdo_q    <= ir_shift_q[0];
          tdo_en_q <= 1'b1;
        end
        S_SHDR: begin
          tdo_q    <= dr_tdo_s;
          tdo_en_q <= 1'b1;
        end
        default: begin
          tdo_q    <= 1'b0;
          tdo_en_q <= 1'b0;
        end
      endcase
    end
  end

  // Strobes decode state flops only, so TMS never reaches the boundary-scan cells combinationally
  assign CaptureDR = (state_q == S_CAPDR) & ~sel_s;
  assign ShiftDR   = (state_q == S_SHDR)  & ~sel_s;
  assign UpdateDR  = (state_q == S_UPDDR) & ~sel_s;
  assign sel       = sel_s;
  assign Mode      = mode_s;
  assign BR        = br_q;
  assign TDO       = tdo_q;
  assign TDO_en    = tdo_en_q;
  assign state     = state_q;

endmodule

// File: tb/tb_tap_controller.sv
// Scoreboard bench for tap_controller: a queue-based TAP model predicts every TCK cycle,
// a separate monitor compares DUT outputs after each falling edge.
module tb_tap_controller;

  localparam logic [3:0] TLR = 4'hF, RTI = 4'hC, SELDR = 4'h7, CAPDR = 4'h6, SHDR = 4'h2,
                         EX1DR = 4'h1, PAUDR = 4'h3, EX2DR = 4'h0, UPDDR = 4'h5,
                         SELIR = 4'h4, CAPIR = 4'hE, SHIR = 4'hA, EX1IR = 4'h9,
                         PAUIR = 4'hB, EX2IR = 4'h8, UPDIR = 4'hD;
`ifdef JTAG_IDCODE_EN
  localparam logic [3:0] RST_IR = 4'b0001;
`else
  localparam logic [3:0] RST_IR = 4'b1111;
`endif

  typedef struct packed {
    logic [3:0] st;
    logic       sel;
    logic       mode;
    logic       cap;
    logic       sh;
    logic       upd;
    logic       en;
    logic       tdo;
    logic       br;
  } exp_t;

  logic       tck = 1'b0;
  logic       trstn = 1'b0;
  logic       tms = 1'b0;
  logic       tdi = 1'b0;
  logic       chain_bit = 1'b0;
  logic       dr;
  logic       sel, br, shift_dr, capture_dr, update_dr, mode, tdo, tdo_en;
  logic [3:0] state;

  int vectors = 0;
  int miscompares = 0;
  exp_t exp_q[$];

  // reference model
  logic [3:0] nxt0 [16];
  logic [3:0] nxt1 [16];
  logic [3:0] m_state;
  logic [3:0] m_ir;
  logic       m_br;
  bit         m_irq[$];
  bit         m_idq[$];

  tap_controller dut (
    .TCK(tck), .TRSTn(trstn), .TMS(tms), .TDI(tdi), .DR(dr),
    .sel(sel), .BR(br), .ShiftDR(shift_dr), .CaptureDR(capture_dr), .UpdateDR(update_dr),
    .Mode(mode), .TDO(tdo), .TDO_en(tdo_en), .state(state)
  );

  // DR mux outside the controller: bypass bit or the boundary-scan chain tail
  assign dr = sel ? br : chain_bit;

  always #5 tck = ~tck;

  task automatic set_edge(input logic [3:0] s, input logic [3:0] n0, input logic [3:0] n1);
    nxt0[s] = n0;
    nxt1[s] = n1;
  endtask

  task automatic init_graph();
    set_edge(TLR, RTI, TLR);     set_edge(RTI, RTI, SELDR);
    set_edge(SELDR, CAPDR, SELIR); set_edge(CAPDR, SHDR, EX1DR);
    set_edge(SHDR, SHDR, EX1DR); set_edge(EX1DR, PAUDR, UPDDR);
    set_edge(PAUDR, PAUDR, EX2DR); set_edge(EX2DR, SHDR, UPDDR);
    set_edge(UPDDR, RTI, SELDR); set_edge(SELIR, CAPIR, TLR);
    set_edge(CAPIR, SHIR, EX1IR); set_edge(SHIR, SHIR, EX1IR);
    set_edge(EX1IR, PAUIR, UPDIR); set_edge(PAUIR, PAUIR, EX2IR);
    set_edge(EX2IR, SHIR, UPDIR); set_edge(UPDIR, RTI, SELDR);
  endtask

  task automatic fill_irq(input logic [3:0] v);
    m_irq.delete();
    for (int i = 0; i < 4; i++) m_irq.push_back(v[i]);
  endtask

  task automatic load_idq();
    logic [31:0] idv;
    idv = 32'h1000_0001;
    m_idq.delete();
    for (int i = 0; i < 32; i++) m_idq.push_back(idv[i]);
  endtask

  function automatic logic m_sel();
    return !((m_ir == 4'b0000) || (m_ir == 4'b0010));
  endfunction

  function automatic exp_t make_exp(input logic ch);
    exp_t e;
    logic id_active;
    id_active = 1'b0;
`ifdef JTAG_IDCODE_EN
    id_active = (m_ir == 4'b0001);
`endif
    e.st   = m_state;
    e.sel  = m_sel();
    e.mode = (m_ir == 4'b0000);
    e.cap  = (m_state == CAPDR) && !e.sel;
    e.sh   = (m_state == SHDR) && !e.sel;
    e.upd  = (m_state == UPDDR) && !e.sel;
    e.en   = (m_state == SHIR) || (m_state == SHDR);
    e.br   = m_br;
    if (m_state == SHIR) e.tdo = m_irq[0];
    else if (m_state == SHDR) e.tdo = id_active ? m_idq[0] : (e.sel ? m_br : ch);
    else e.tdo = 1'b0;
    return e;
  endfunction

  task automatic pulse_reset();
    @(negedge tck); #3;
    trstn   = 1'b0;
    m_state = TLR;
    m_ir    = RST_IR;
    m_br    = 1'b0;
    fill_irq(4'b0000);
    load_idq();
    exp_q.push_back(make_exp(1'b0));
  endtask

  // One TCK cycle: drive pins, advance the model, queue the expected post-falling-edge view
  task automatic step(input logic t_ms, input logic t_di);
    logic [3:0] pre;
    logic       ch;
    logic [3:0] packed_ir;
    @(negedge tck); #3;
    trstn = 1'b1;
    ch = 1'($urandom_range(0, 1));
    tms = t_ms; tdi = t_di; chain_bit = ch;
    pre = m_state;
    if (pre == TLR) begin
      m_br = 1'b0;
      fill_irq(4'b0000);
    end else if (pre == CAPIR) begin
      fill_irq(4'b0001);
    end else if (pre == SHIR) begin
      void'(m_irq.pop_front());
      m_irq.push_back(t_di);
    end else if (pre == CAPDR) begin
      if (m_sel()) m_br = 1'b0;
      load_idq();
    end else if (pre == SHDR) begin
      if (m_sel()) m_br = t_di;
      void'(m_idq.pop_front());
      m_idq.push_back(t_di);
    end
    m_state = t_ms ? nxt1[pre] : nxt0[pre];
    if (m_state == UPDIR) begin
      for (int i = 0; i < 4; i++) packed_ir[i] = m_irq[i];
      m_ir = packed_ir;
    end else if (m_state == TLR) begin
      m_ir = RST_IR;
    end
    exp_q.push_back(make_exp(ch));
  endtask

  task automatic load_ir(input logic [3:0] opc);
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(i == 3, opc[i]);
    step(1'b1, 1'b0); step(1'b0, 1'b0);
  endtask

  task automatic scan_dr(input int n, input logic [31:0] bits);
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int i = 0; i < n; i++) step(i == n - 1, bits[i]);
    step(1'b1, 1'b0); step(1'b0, 1'b0);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Monitor: compares after each falling edge, once TDO and IR have settled
  initial begin
    exp_t e;
    forever begin
      @(negedge tck); #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("state", 32'(state), 32'(e.st));
        chk("sel", 32'(sel), 32'(e.sel));
        chk("Mode", 32'(mode), 32'(e.mode));
        chk("CaptureDR", 32'(capture_dr), 32'(e.cap));
        chk("ShiftDR", 32'(shift_dr), 32'(e.sh));
        chk("UpdateDR", 32'(update_dr), 32'(e.upd));
        chk("TDO_en", 32'(tdo_en), 32'(e.en));
        chk("TDO", 32'(tdo), 32'(e.tdo));
        chk("BR", 32'(br), 32'(e.br));
      end
    end
  end

  initial begin
    int plen [16];
    logic [7:0] pbits [16];
    init_graph();
    plen[TLR] = 0;   pbits[TLR] = 8'b0;
    plen[RTI] = 1;   pbits[RTI] = 8'b0;
    plen[SELDR] = 2; pbits[SELDR] = 8'b10;
    plen[CAPDR] = 3; pbits[CAPDR] = 8'b010;
    plen[SHDR] = 4;  pbits[SHDR] = 8'b0010;
    plen[EX1DR] = 4; pbits[EX1DR] = 8'b1010;
    plen[PAUDR] = 5; pbits[PAUDR] = 8'b01010;
    plen[EX2DR] = 6; pbits[EX2DR] = 8'b101010;
    plen[UPDDR] = 5; pbits[UPDDR] = 8'b11010;
    plen[SELIR] = 3; pbits[SELIR] = 8'b110;
    plen[CAPIR] = 4; pbits[CAPIR] = 8'b0110;
    plen[SHIR] = 5;  pbits[SHIR] = 8'b00110;
    plen[EX1IR] = 5; pbits[EX1IR] = 8'b10110;
    plen[PAUIR] = 6; pbits[PAUIR] = 8'b010110;
    plen[EX2IR] = 7; pbits[EX2IR] = 8'b1010110;
    plen[UPDIR] = 6; pbits[UPDIR] = 8'b110110;

    pulse_reset();
    step(1'b0, 1'b0);

    // directed instruction/data scans, including the classic bypass pattern
    load_ir(4'b0000); scan_dr(8, $urandom);
    load_ir(4'b0010); scan_dr(6, $urandom);
    load_ir(4'b1111); scan_dr(8, 32'h0000_004D);
    load_ir(4'b0101); scan_dr(5, $urandom);
    load_ir(4'b0001); scan_dr(32, $urandom);

    // reset in the middle of a data shift
    load_ir(4'b0000);
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    step(1'b0, 1'b1); step(1'b0, 1'b0);
    pulse_reset();
    step(1'b0, 1'b0);

    // five TMS=1 clocks reach TLR from every state
    for (int s = 0; s < 16; s++) begin
      for (int k = 0; k < 5; k++) step(1'b1, 1'b0);
      for (int k = 0; k < plen[s]; k++) step(pbits[s][k], 1'($urandom_range(0, 1)));
      for (int k = 0; k < 5; k++) step(1'b1, 1'($urandom_range(0, 1)));
    end

    // random walk with occasional asynchronous resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) pulse_reset();
      else step($urandom_range(0, 7) < 3, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge tck);
    #4;
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
